// File: rtl/snes_bus_event_capture.sv
// SNES bus observer: synchronises the raw async address/data bus, captures each settled
// address change, filters it through a match/mask and queues matches in a small event FIFO.
module snes_bus_event_capture #(
  parameter int AW          = 8,
  parameter int DW          = 8,
  parameter int SYNC_STAGES = 3,
  parameter int LATCH_DLY   = 4,
  parameter int MIN_GAP     = 5,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [AW-1:0]                 PA,
  input  logic [DW-1:0]                 D,
  input  logic [AW-1:0]                 match_addr,
  input  logic [AW-1:0]                 match_mask,
  output logic [AW-1:0]                 PA_sync,
  output logic                          event_latch,
  output logic                          ev_valid,
  output logic [AW-1:0]                 ev_addr,
  output logic [DW-1:0]                 ev_data,
  input  logic                          ev_ready,
  output logic [$clog2(FIFO_DEPTH):0]   ev_count,
  output logic                          overflow,
  input  logic                          ovf_clr
);

  localparam int CW  = $clog2(FIFO_DEPTH) + 1;
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int GW  = (MIN_GAP < 1) ? 1 : $clog2(MIN_GAP + 1);
  localparam int DLW = (LATCH_DLY > 1) ? $clog2(LATCH_DLY) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_WAIT   = 2'd2
  } state_t;

  logic [AW-1:0]  s [SYNC_STAGES];
  logic [DW-1:0]  dq0, dq1;
  logic           stable;

  state_t         state, state_next;
  logic [DLW-1:0] dly_cnt, dly_next;
  logic [GW-1:0]  gap_cnt, gap_next;
  logic           capture;
  logic           match;

  logic           push_pend;
  logic [AW-1:0]  push_addr;
  logic [DW-1:0]  push_data;

  logic [AW-1:0]  mem_addr [FIFO_DEPTH];
  logic [DW-1:0]  mem_data [FIFO_DEPTH];
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  count;
  logic           full, pop, push_ok, drop;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) s[i] <= '0;
      dq0 <= '0;
      dq1 <= '0;
    end else begin
      s[0] <= PA;
      for (int i = 1; i < SYNC_STAGES; i++) s[i] <= s[i-1];
      dq0 <= D;
      dq1 <= dq0;
    end
  end

  assign PA_sync = s[SYNC_STAGES-1];

  // The raw pin must agree with every stage, so a settled value has survived the whole window.
  always_comb begin
    stable = (PA == s[0]);
    for (int i = 1; i < SYNC_STAGES; i++) begin
      if (s[i] != s[i-1]) stable = 1'b0;
    end
  end

  assign match = (((PA_sync ^ match_addr) & match_mask) == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      dly_cnt <= '0;
      gap_cnt <= '0;
    end else begin
      state   <= state_next;
      dly_cnt <= dly_next;
      gap_cnt <= gap_next;
    end
  end

  always_comb begin
    state_next = state;
    dly_next   = dly_cnt;
    gap_next   = gap_cnt;
    capture    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (gap_cnt < GW'(MIN_GAP)) gap_next = gap_cnt + GW'(1);
        if (!stable && (gap_cnt >= GW'(MIN_GAP))) state_next = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (stable) begin
          state_next = ST_WAIT;
          dly_next   = '0;
        end
      end
      ST_WAIT: begin
        if (!stable) begin
          state_next = ST_SETTLE;
        end else if (dly_cnt == DLW'(LATCH_DLY - 1)) begin
          capture    = 1'b1;
          state_next = ST_IDLE;
          gap_next   = '0;
        end else begin
          dly_next = dly_cnt + DLW'(1);
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Captured entry is staged one cycle so the FIFO head appears right after the pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      event_latch <= 1'b0;
      push_pend   <= 1'b0;
      push_addr   <= '0;
      push_data   <= '0;
    end else begin
      event_latch <= capture;
      push_pend   <= capture && match;
      if (capture) begin
        push_addr <= PA_sync;
        push_data <= dq1;
      end
    end
  end

  assign full    = (count == CW'(FIFO_DEPTH));
  assign ev_valid = (count != '0);
  assign pop     = ev_valid && ev_ready;
  assign push_ok = push_pend && (!full || pop);
  assign drop    = push_pend && full && !pop;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_addr[wr_ptr] <= push_addr;
      mem_data[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (drop)         overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  assign ev_addr  = mem_addr[rd_ptr];
  assign ev_data  = mem_data[rd_ptr];
  assign ev_count = count;

endmodule
